// File: rtl/uart_rx_fsm.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fsm
// Description : UART receiver control FSM. Detects the start bit, counts
//               oversampling edges and data-bit positions, sequences
//               START/DATA/PARITY/STOP and drives the checker enables.
//               Issues a one-cycle data_valid for every good frame.
//               Optional feature macro: UART_RX_FRAMING_ERR_EN adds a
//               one-cycle frame_err pulse for frames dropped on par/stp error.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fsm #(
   parameter  int DATA_WIDTH = 8,
   localparam int BIT_W      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             RX_IN,
   input  logic             PAR_EN,
   input  logic [5:0]       Prescale,
   input  logic             strt_glitch,
   input  logic             par_err,
   input  logic             stp_err,
   output logic [4:0]       edge_count,
   output logic [BIT_W-1:0] bit_count,
   output logic             dat_samp_en,
   output logic             deser_en,
   output logic             strt_chk_en,
   output logic             parity_check_en,
   output logic             stp_chk_en,
   output logic             data_valid
`ifdef UART_RX_FRAMING_ERR_EN
   ,
   output logic             frame_err
`endif
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [4:0]       edge_count_q, edge_count_d;
   logic [BIT_W-1:0] bit_count_q, bit_count_d;
   logic [5:0]       prescale_q, prescale_d;
   logic             par_en_q, par_en_d;
   logic             data_valid_q, data_valid_d;
`ifdef UART_RX_FRAMING_ERR_EN
   logic             frame_err_q, frame_err_d;
`endif

   logic at_chk;
   logic at_end;
   logic last_bit;
   logic frame_good;

   // CHK point sits two edges past mid-bit so the sampled value has settled
   assign at_chk     = ({1'b0, edge_count_q} == ({1'b0, prescale_q[5:1]} + 6'd2));
   assign at_end     = ({1'b0, edge_count_q} == (prescale_q - 6'd1));
   assign last_bit   = (bit_count_q == BIT_W'(DATA_WIDTH - 1));
   // par_err only matters when the latched frame format actually has parity
   assign frame_good = !stp_err && !(par_en_q && par_err);

   // Next-state, counter and strobe logic
   always_comb begin
      state_d      = state_q;
      edge_count_d = edge_count_q;
      bit_count_d  = bit_count_q;
      prescale_d   = prescale_q;
      par_en_d     = par_en_q;
      data_valid_d = 1'b0;
`ifdef UART_RX_FRAMING_ERR_EN
      frame_err_d  = 1'b0;
`endif
      if (state_q != S_IDLE) begin
         edge_count_d = at_end ? 5'd0 : (edge_count_q + 5'd1);
      end
      case (state_q)
         S_IDLE: begin
            edge_count_d = 5'd0;
            bit_count_d  = '0;
            if (!RX_IN) begin
               // frame format is frozen here for the whole frame
               state_d    = S_START;
               prescale_d = Prescale;
               par_en_d   = PAR_EN;
            end
         end
         S_START: begin
            if (at_end) begin
               bit_count_d = '0;
               state_d     = strt_glitch ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (at_end) begin
               if (last_bit) begin
                  bit_count_d = '0;
                  state_d     = par_en_q ? S_PARITY : S_STOP;
               end else begin
                  bit_count_d = bit_count_q + BIT_W'(1);
               end
            end
         end
         S_PARITY: begin
            if (at_end) begin
               state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (at_end) begin
               data_valid_d = frame_good;
`ifdef UART_RX_FRAMING_ERR_EN
               frame_err_d  = !frame_good;
`endif
               // a low line here is the next start bit, no idle gap needed
               state_d      = RX_IN ? S_IDLE : S_START;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and counter registers with asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         edge_count_q <= 5'd0;
         bit_count_q  <= '0;
         prescale_q   <= 6'd8;
         par_en_q     <= 1'b0;
         data_valid_q <= 1'b0;
`ifdef UART_RX_FRAMING_ERR_EN
         frame_err_q  <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         edge_count_q <= edge_count_d;
         bit_count_q  <= bit_count_d;
         prescale_q   <= prescale_d;
         par_en_q     <= par_en_d;
         data_valid_q <= data_valid_d;
`ifdef UART_RX_FRAMING_ERR_EN
         frame_err_q  <= frame_err_d;
`endif
      end
   end

   assign edge_count      = edge_count_q;
   assign bit_count       = bit_count_q;
   assign dat_samp_en     = (state_q != S_IDLE);
   assign strt_chk_en     = (state_q == S_START);
   assign parity_check_en = (state_q == S_PARITY);
   assign stp_chk_en      = (state_q == S_STOP);
   assign deser_en        = (state_q == S_DATA) && at_chk;
   assign data_valid      = data_valid_q;
`ifdef UART_RX_FRAMING_ERR_EN
   assign frame_err       = frame_err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_fsm
// Description : Directed testbench for uart_rx_fsm. Drives serial frames,
//               counts enable/strobe activity per frame and compares it
//               against hand-computed expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fsm;

   logic       clk = 1'b0;
   logic       rst;
   logic       RX_IN;
   logic       PAR_EN;
   logic [5:0] Prescale;
   logic       strt_glitch;
   logic       par_err;
   logic       stp_err;
   logic [4:0] edge_count;
   logic [2:0] bit_count;
   logic       dat_samp_en;
   logic       deser_en;
   logic       strt_chk_en;
   logic       parity_check_en;
   logic       stp_chk_en;
   logic       data_valid;
`ifdef UART_RX_FRAMING_ERR_EN
   logic       frame_err;
`endif

   uart_rx_fsm #(.DATA_WIDTH(8)) u_dut (
      .clk             (clk),
      .rst             (rst),
      .RX_IN           (RX_IN),
      .PAR_EN          (PAR_EN),
      .Prescale        (Prescale),
      .strt_glitch     (strt_glitch),
      .par_err         (par_err),
      .stp_err         (stp_err),
      .edge_count      (edge_count),
      .bit_count       (bit_count),
      .dat_samp_en     (dat_samp_en),
      .deser_en        (deser_en),
      .strt_chk_en     (strt_chk_en),
      .parity_check_en (parity_check_en),
      .stp_chk_en      (stp_chk_en),
      .data_valid      (data_valid)
`ifdef UART_RX_FRAMING_ERR_EN
      ,
      .frame_err       (frame_err)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Activity monitor, sampled on the falling edge
   int m_deser = 0, m_dv = 0, m_strt = 0, m_par = 0, m_stp = 0, m_samp = 0, m_ferr = 0;
   int m_dv_cyc = 0, m_dv_prev = 0, m_deser_edge = 0, m_bit_sum = 0, m_max_edge = 0;
   always @(negedge clk) begin
      if (deser_en === 1'b1) begin
         m_deser++;
         m_deser_edge = int'(edge_count);
         m_bit_sum += int'(bit_count);
      end
      if (data_valid === 1'b1) begin
         m_dv++;
         m_dv_prev = m_dv_cyc;
         m_dv_cyc  = cyc;
      end
      if (strt_chk_en === 1'b1)     m_strt++;
      if (parity_check_en === 1'b1) m_par++;
      if (stp_chk_en === 1'b1)      m_stp++;
      if (dat_samp_en === 1'b1)     m_samp++;
`ifdef UART_RX_FRAMING_ERR_EN
      if (frame_err === 1'b1)       m_ferr++;
`endif
      if (int'(edge_count) > m_max_edge) m_max_edge = int'(edge_count);
   end

   int s_deser, s_dv, s_strt, s_par, s_stp, s_samp, s_ferr, s_bit_sum;
   int n_vec = 0;
   int n_bad = 0;
   int t0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic snap();
      s_deser   = m_deser;
      s_dv      = m_dv;
      s_strt    = m_strt;
      s_par     = m_par;
      s_stp     = m_stp;
      s_samp    = m_samp;
      s_ferr    = m_ferr;
      s_bit_sum = m_bit_sum;
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b, input int p);
      RX_IN = b;
      tick(p);
   endtask

   // scramble: change Prescale/PAR_EN right after the start bit
   task automatic send_frame(input logic [7:0] d, input logic par_on, input logic par_bit,
                             input logic stp_bit, input int p, input logic scramble);
      send_bit(1'b0, p);
      if (scramble) begin
         Prescale = 6'd16;
         PAR_EN   = ~PAR_EN;
      end
      for (int i = 0; i < 8; i++) send_bit(d[i], p);
      if (par_on) send_bit(par_bit, p);
      send_bit(stp_bit, p);
   endtask

   initial begin
      rst = 1'b1; RX_IN = 1'b1; PAR_EN = 1'b0; Prescale = 6'd8;
      strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
      tick(3);
      check_eq("rst_enables", 32'({dat_samp_en, deser_en, strt_chk_en, parity_check_en, stp_chk_en, data_valid}), 32'd0);
      check_eq("rst_edge_count", 32'(edge_count), 32'd0);
      check_eq("rst_bit_count", 32'(bit_count), 32'd0);
      rst = 1'b0;
      tick(3);

      // 1: P=8, even parity, 0xA5 -> parity 0; mid-frame format change ignored
      Prescale = 6'd8; PAR_EN = 1'b1;
      snap(); t0 = cyc;
      send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 8, 1'b1);
      RX_IN = 1'b1; Prescale = 6'd8; PAR_EN = 1'b1;
      tick(4);
      check_eq("t1_deser", 32'(m_deser - s_deser), 32'd8);
      check_eq("t1_dv", 32'(m_dv - s_dv), 32'd1);
      check_eq("t1_dv_time", 32'(m_dv_cyc - t0), 32'd89);
      check_eq("t1_chk_edge", 32'(m_deser_edge), 32'd6);
      check_eq("t1_bit_sum", 32'(m_bit_sum - s_bit_sum), 32'd28);
      check_eq("t1_strt_cyc", 32'(m_strt - s_strt), 32'd8);
      check_eq("t1_par_cyc", 32'(m_par - s_par), 32'd8);
      check_eq("t1_stp_cyc", 32'(m_stp - s_stp), 32'd8);
      check_eq("t1_samp_cyc", 32'(m_samp - s_samp), 32'd88);
      check_eq("t1_max_edge", 32'(m_max_edge), 32'd7);
      check_eq("t1_ferr", 32'(m_ferr - s_ferr), 32'd0);

      // 2: same frame, parity bit flipped, par_err raised
      snap(); par_err = 1'b1;
      send_frame(8'hA5, 1'b1, 1'b1, 1'b1, 8, 1'b0);
      RX_IN = 1'b1;
      tick(4);
      par_err = 1'b0;
      check_eq("t2_deser", 32'(m_deser - s_deser), 32'd8);
      check_eq("t2_dv", 32'(m_dv - s_dv), 32'd0);
`ifdef UART_RX_FRAMING_ERR_EN
      check_eq("t2_ferr", 32'(m_ferr - s_ferr), 32'd1);
`endif
      check_eq("t2_idle", 32'(dat_samp_en), 32'd0);

      // 3: 3-cycle start glitch
      snap(); strt_glitch = 1'b1;
      RX_IN = 1'b0; tick(3);
      RX_IN = 1'b1; tick(12);
      strt_glitch = 1'b0;
      check_eq("t3_strt_cyc", 32'(m_strt - s_strt), 32'd8);
      check_eq("t3_samp_cyc", 32'(m_samp - s_samp), 32'd8);
      check_eq("t3_deser", 32'(m_deser - s_deser), 32'd0);
      check_eq("t3_dv", 32'(m_dv - s_dv), 32'd0);
      check_eq("t3_ferr", 32'(m_ferr - s_ferr), 32'd0);
      check_eq("t3_idle", 32'(dat_samp_en), 32'd0);

      // 4: P=32, no parity, back-to-back 0x3C / 0xFF
      Prescale = 6'd32; PAR_EN = 1'b0;
      snap(); t0 = cyc;
      send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 32, 1'b0);
      send_frame(8'hFF, 1'b0, 1'b0, 1'b1, 32, 1'b0);
      RX_IN = 1'b1;
      tick(4);
      check_eq("t4_dv", 32'(m_dv - s_dv), 32'd2);
      check_eq("t4_dv_first", 32'(m_dv_prev - t0), 32'd321);
      check_eq("t4_dv_gap", 32'(m_dv_cyc - m_dv_prev), 32'd320);
      check_eq("t4_deser", 32'(m_deser - s_deser), 32'd16);
      check_eq("t4_strt_cyc", 32'(m_strt - s_strt), 32'd64);
      check_eq("t4_samp_cyc", 32'(m_samp - s_samp), 32'd640);
      check_eq("t4_chk_edge", 32'(m_deser_edge), 32'd18);
      check_eq("t4_max_edge", 32'(m_max_edge), 32'd31);

      // 5: reset during data bit 4, then a clean frame
      Prescale = 6'd8; PAR_EN = 1'b0;
      snap();
      send_bit(1'b0, 8);
      for (int i = 0; i < 4; i++) send_bit(i[0], 8);
      RX_IN = 1'b1;
      tick(2);
      check_eq("t5_bit_before", 32'(bit_count), 32'd4);
      #2 rst = 1'b1;
      #1;
      check_eq("t5_rst_enables", 32'({dat_samp_en, deser_en, strt_chk_en, parity_check_en, stp_chk_en, data_valid}), 32'd0);
      check_eq("t5_rst_counts", 32'({edge_count, bit_count}), 32'd0);
      tick(2);
      rst = 1'b0;
      tick(2);
      t0 = cyc;
      send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 8, 1'b0);
      tick(4);
      check_eq("t5_dv", 32'(m_dv - s_dv), 32'd1);
      check_eq("t5_dv_time", 32'(m_dv_cyc - t0), 32'd81);
      check_eq("t5_deser", 32'(m_deser - s_deser), 32'd12);

      // 6a: P=16, stop error, line high at STOP END -> IDLE
      Prescale = 6'd16; PAR_EN = 1'b0;
      snap(); stp_err = 1'b1;
      send_frame(8'h81, 1'b0, 1'b0, 1'b0, 16, 1'b0);
      RX_IN = 1'b1;
      tick(3);
      check_eq("t6a_dv", 32'(m_dv - s_dv), 32'd0);
      check_eq("t6a_stp_cyc", 32'(m_stp - s_stp), 32'd16);
      check_eq("t6a_idle", 32'(dat_samp_en), 32'd0);
`ifdef UART_RX_FRAMING_ERR_EN
      check_eq("t6a_ferr", 32'(m_ferr - s_ferr), 32'd1);
`endif

      // 6b: stop error, line low at STOP END -> START
      snap();
      send_frame(8'h81, 1'b0, 1'b0, 1'b0, 16, 1'b0);
      tick(1);
      check_eq("t6b_start", 32'(strt_chk_en), 32'd1);
      check_eq("t6b_edge0", 32'(edge_count), 32'd0);
      tick(1);
      RX_IN = 1'b1; strt_glitch = 1'b1;
      tick(20);
      strt_glitch = 1'b0; stp_err = 1'b0;
      check_eq("t6b_dv", 32'(m_dv - s_dv), 32'd0);
      check_eq("t6b_idle", 32'(dat_samp_en), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
